// File: rtl/cnn_pkg.sv
// Shared CNN definitions: sample width, signed sample type and feature-map geometry.
package cnn_pkg;

    localparam int DATA_BITS     = 12;
    localparam int FM_IN_WIDTH   = 8;
    localparam int FM_IN_HEIGHT  = 8;
    localparam int FM_OUT_WIDTH  = 4;
    localparam int FM_OUT_HEIGHT = 4;
    localparam int NUM_CHANNELS  = 3;

    typedef logic signed [DATA_BITS-1:0] sample_t;

endpackage

// File: rtl/maxpool_relu_pool_channel.sv
// One channel of the 2x2 max-pool: pixel hold register, half-width line buffer,
// three-way signed compare and optional ReLU (enabled by MAXPOOL_RELU_EN).
module pool_channel
    import cnn_pkg::*;
#(
    parameter int IN_WIDTH  = FM_IN_WIDTH,
    parameter int DATA_BITS = cnn_pkg::DATA_BITS,
    parameter int IDX_W     = (IN_WIDTH / 2 > 1) ? $clog2(IN_WIDTH / 2) : 1
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        hold_en,
    input  logic                        lb_wr_en,
    input  logic                        out_en,
    input  logic [IDX_W-1:0]            lb_idx,
    input  logic signed [DATA_BITS-1:0] data_in,
    output logic signed [DATA_BITS-1:0] data_out
);

    function automatic logic signed [DATA_BITS-1:0] smax(
        input logic signed [DATA_BITS-1:0] a,
        input logic signed [DATA_BITS-1:0] b
    );
        return (a > b) ? a : b;
    endfunction

    logic signed [DATA_BITS-1:0] hold_r;
    logic signed [DATA_BITS-1:0] linebuf_r [IN_WIDTH/2];
    logic signed [DATA_BITS-1:0] data_out_r;
    logic signed [DATA_BITS-1:0] pair_max_s;
    logic signed [DATA_BITS-1:0] win_max_s;
    logic signed [DATA_BITS-1:0] result_s;

    // Compare tree: horizontal pair first, then against the row-above pair.
    always_comb begin
        pair_max_s = smax(hold_r, data_in);
        win_max_s  = smax(linebuf_r[lb_idx], pair_max_s);
`ifdef MAXPOOL_RELU_EN
        if (win_max_s[DATA_BITS-1]) begin
            result_s = {DATA_BITS{1'b0}};
        end else begin
            result_s = win_max_s;
        end
`else
        result_s = win_max_s;
`endif
    end

    // Window storage; contents are don't-care after reset and always rewritten before use.
    always_ff @(posedge clk) begin
        if (hold_en) begin
            hold_r <= data_in;
        end
        if (lb_wr_en) begin
            linebuf_r[lb_idx] <= pair_max_s;
        end
    end

    // Registered pooled result, held until the next window completes.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            data_out_r <= {DATA_BITS{1'b0}};
        end else if (out_en) begin
            data_out_r <= result_s;
        end
    end

    assign data_out = data_out_r;

endmodule

// File: rtl/maxpool_relu.sv
// Streaming 2x2/stride-2 max-pool (+ ReLU when MAXPOOL_RELU_EN is defined) for three channels.
// Owns the raster counters, window-position decode and the valid_out/frame_done pulses.
module maxpool_relu
    import cnn_pkg::*;
#(
    parameter int IN_WIDTH  = FM_IN_WIDTH,
    parameter int IN_HEIGHT = FM_IN_HEIGHT,
    parameter int DATA_BITS = cnn_pkg::DATA_BITS
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        valid_in,
    input  logic signed [DATA_BITS-1:0] data_in_1,
    input  logic signed [DATA_BITS-1:0] data_in_2,
    input  logic signed [DATA_BITS-1:0] data_in_3,
    output logic                        valid_out,
    output logic signed [DATA_BITS-1:0] data_out_1,
    output logic signed [DATA_BITS-1:0] data_out_2,
    output logic signed [DATA_BITS-1:0] data_out_3,
    output logic                        frame_done
);

    localparam int COL_W = $clog2(IN_WIDTH);
    localparam int ROW_W = $clog2(IN_HEIGHT);
    localparam int IDX_W = (IN_WIDTH / 2 > 1) ? $clog2(IN_WIDTH / 2) : 1;

    logic [COL_W-1:0] col_r;
    logic [ROW_W-1:0] row_r;
    logic             valid_out_r;
    logic             frame_done_r;
    logic             last_col_s;
    logic             last_row_s;
    logic             hold_en_s;
    logic             lb_wr_en_s;
    logic             out_en_s;
    logic [IDX_W-1:0] lb_idx_s;

    // Window-position decode shared by all three channels.
    always_comb begin
        last_col_s = (col_r == COL_W'(IN_WIDTH - 1));
        last_row_s = (row_r == ROW_W'(IN_HEIGHT - 1));
        hold_en_s  = valid_in & ~col_r[0];
        lb_wr_en_s = valid_in &  col_r[0] & ~row_r[0];
        out_en_s   = valid_in &  col_r[0] &  row_r[0];
        lb_idx_s   = IDX_W'(col_r >> 1);
    end

    // Raster counters and output strobes; reset also cancels a pending pulse.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            col_r        <= {COL_W{1'b0}};
            row_r        <= {ROW_W{1'b0}};
            valid_out_r  <= 1'b0;
            frame_done_r <= 1'b0;
        end else begin
            valid_out_r  <= out_en_s;
            frame_done_r <= out_en_s & last_row_s & last_col_s;
            if (valid_in) begin
                if (last_col_s) begin
                    col_r <= {COL_W{1'b0}};
                    row_r <= last_row_s ? {ROW_W{1'b0}} : row_r + ROW_W'(1);
                end else begin
                    col_r <= col_r + COL_W'(1);
                end
            end
        end
    end

    assign valid_out  = valid_out_r;
    assign frame_done = frame_done_r;

    pool_channel #(.IN_WIDTH(IN_WIDTH), .DATA_BITS(DATA_BITS), .IDX_W(IDX_W)) u_ch1 (
        .clk(clk), .rst_n(rst_n), .hold_en(hold_en_s), .lb_wr_en(lb_wr_en_s),
        .out_en(out_en_s), .lb_idx(lb_idx_s), .data_in(data_in_1), .data_out(data_out_1)
    );

    pool_channel #(.IN_WIDTH(IN_WIDTH), .DATA_BITS(DATA_BITS), .IDX_W(IDX_W)) u_ch2 (
        .clk(clk), .rst_n(rst_n), .hold_en(hold_en_s), .lb_wr_en(lb_wr_en_s),
        .out_en(out_en_s), .lb_idx(lb_idx_s), .data_in(data_in_2), .data_out(data_out_2)
    );

    pool_channel #(.IN_WIDTH(IN_WIDTH), .DATA_BITS(DATA_BITS), .IDX_W(IDX_W)) u_ch3 (
        .clk(clk), .rst_n(rst_n), .hold_en(hold_en_s), .lb_wr_en(lb_wr_en_s),
        .out_en(out_en_s), .lb_idx(lb_idx_s), .data_in(data_in_3), .data_out(data_out_3)
    );

endmodule

// File: tb/tb_maxpool_relu.sv
// Randomized self-checking bench for maxpool_relu against a frame-array reference model.
module tb_maxpool_relu;

    localparam int W  = 8;
    localparam int H  = 8;
    localparam int DB = 12;

`ifdef MAXPOOL_RELU_EN
    localparam int EXP_NEG5 = 0;
    localparam int EXP_NEG3 = 0;
`else
    localparam int EXP_NEG5 = -5;
    localparam int EXP_NEG3 = -3;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                 rst_n;
    logic                 valid_in;
    logic signed [DB-1:0] data_in_1, data_in_2, data_in_3;
    logic                 valid_out;
    logic signed [DB-1:0] data_out_1, data_out_2, data_out_3;
    logic                 frame_done;

    maxpool_relu dut (
        .clk(clk), .rst_n(rst_n), .valid_in(valid_in),
        .data_in_1(data_in_1), .data_in_2(data_in_2), .data_in_3(data_in_3),
        .valid_out(valid_out),
        .data_out_1(data_out_1), .data_out_2(data_out_2), .data_out_3(data_out_3),
        .frame_done(frame_done)
    );

    int checks = 0;
    int errors = 0;

    // reference model state
    int img [3][H][W];
    int pix_cnt = 0;
    int frame [3][H*W];
    bit cur_chk = 1'b0, next_chk = 1'b0;
    bit exp_cur_v = 1'b0, exp_next_v = 1'b0;
    bit exp_cur_fd = 1'b0, exp_next_fd = 1'b0;
    int exp_cur_d [3];
    int exp_next_d [3];

    bit cap_en = 1'b0;
    int cap1 [$];
    int fd_cnt = 0;

    function automatic int relu(input int v);
`ifdef MAXPOOL_RELU_EN
        return (v < 0) ? 0 : v;
`else
        return v;
`endif
    endfunction

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    function automatic int rnd_sample();
        return int'($urandom_range(4095)) - 2048;
    endfunction

    task automatic check(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
        end
    endtask

    // One clock: promote the expectation for the edge just taken, drive new inputs, predict.
    task automatic step(input bit rst, input bit v, input int a, input int b, input int c);
        int vals [3];
        int r, cc, m;
        @(posedge clk);
        #1;
        exp_cur_v  = exp_next_v;
        exp_cur_fd = exp_next_fd;
        exp_cur_d  = exp_next_d;
        cur_chk    = next_chk;
        vals[0] = a; vals[1] = b; vals[2] = c;
        rst_n     = ~rst;
        valid_in  = v;
        data_in_1 = DB'(a);
        data_in_2 = DB'(b);
        data_in_3 = DB'(c);
        exp_next_v  = 1'b0;
        exp_next_fd = 1'b0;
        if (rst) begin
            pix_cnt  = 0;
            next_chk = 1'b1;
            for (int ch = 0; ch < 3; ch++) exp_next_d[ch] = 0;
        end else if (v) begin
            r  = pix_cnt / W;
            cc = pix_cnt % W;
            for (int ch = 0; ch < 3; ch++) img[ch][r][cc] = vals[ch];
            if ((r % 2 == 1) && (cc % 2 == 1)) begin
                for (int ch = 0; ch < 3; ch++) begin
                    m = max2(max2(img[ch][r-1][cc-1], img[ch][r-1][cc]),
                             max2(img[ch][r][cc-1], img[ch][r][cc]));
                    exp_next_d[ch] = relu(m);
                end
                exp_next_v  = 1'b1;
                exp_next_fd = (r == H - 1) && (cc == W - 1);
            end
            pix_cnt = (pix_cnt + 1) % (W * H);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, rnd_sample(), rnd_sample(), rnd_sample());
    endtask

    task automatic send_pixels(input int first, input int last, input int gap_pct);
        for (int p = first; p <= last; p++) begin
            while (int'($urandom_range(99)) < gap_pct) begin
                step(1'b0, 1'b0, rnd_sample(), rnd_sample(), rnd_sample());
            end
            step(1'b0, 1'b1, frame[0][p], frame[1][p], frame[2][p]);
        end
    endtask

    task automatic fill_ramp(input int off);
        for (int p = 0; p < H * W; p++) begin
            frame[0][p] = p + off;
            frame[1][p] = -5;
            frame[2][p] = rnd_sample();
        end
    endtask

    task automatic fill_random();
        for (int p = 0; p < H * W; p++) begin
            for (int ch = 0; ch < 3; ch++) frame[ch][p] = rnd_sample();
        end
    endtask

    task automatic start_capture();
        cap1.delete();
        fd_cnt = 0;
        cap_en = 1'b1;
    endtask

    // Pin the ramp results with the closed form (2R+1)*8 + 2C+1 (+ per-frame offset).
    task automatic check_ramp(input string name, input int off0, input int off1, input int nframes);
        int f, k, ex;
        cap_en = 1'b0;
        check({name, "_count"}, cap1.size(), 16 * nframes);
        check({name, "_frame_done"}, fd_cnt, nframes);
        for (int i = 0; i < cap1.size() && i < 16 * nframes; i++) begin
            f  = i / 16;
            k  = i % 16;
            ex = (2 * (k / 4) + 1) * W + 2 * (k % 4) + 1 + ((f == 0) ? off0 : off1);
            check({name, "_value"}, cap1[i], ex);
        end
    endtask

    // Compare process: every output against the model on each falling edge.
    always @(negedge clk) begin
        if (cur_chk) begin
            check("valid_out", int'(valid_out), int'(exp_cur_v));
            check("frame_done", int'(frame_done), int'(exp_cur_fd));
            check("data_out_1", int'(data_out_1), exp_cur_d[0]);
            check("data_out_2", int'(data_out_2), exp_cur_d[1]);
            check("data_out_3", int'(data_out_3), exp_cur_d[2]);
            if (cap_en && valid_out) cap1.push_back(int'(data_out_1));
            if (cap_en && frame_done) fd_cnt++;
        end
    end

    initial begin
        rst_n = 1'b0;
        valid_in = 1'b0;
        data_in_1 = '0;
        data_in_2 = '0;
        data_in_3 = '0;
        for (int i = 0; i < 3; i++) begin
            exp_cur_d[i]  = 0;
            exp_next_d[i] = 0;
        end

        repeat (3) step(1'b1, 1'b0, 0, 0, 0);
        idle(2);

        // ramp frame, constant -5 channel
        fill_ramp(0);
        start_capture();
        send_pixels(0, H * W - 1, 0);
        idle(2);
        check_ramp("ramp", 0, 0, 1);
        check("relu_neg5", int'(data_out_2), EXP_NEG5);

        // signed compare windows
        fill_random();
        frame[0][0] = -2048; frame[0][1] = 2047; frame[0][8]  = -1; frame[0][9]  = 0;
        frame[0][2] = -7;    frame[0][3] = -3;   frame[0][10] = -9; frame[0][11] = -4;
        start_capture();
        send_pixels(0, H * W - 1, 0);
        idle(2);
        cap_en = 1'b0;
        check("signed_count", cap1.size(), 16);
        if (cap1.size() >= 2) begin
            check("signed_win0", cap1[0], 2047);
            check("signed_win1", cap1[1], EXP_NEG3);
        end

        // gapped ramp
        fill_ramp(0);
        start_capture();
        send_pixels(0, H * W - 1, 50);
        idle(2);
        check_ramp("gapped", 0, 0, 1);

        // back-to-back frames, second offset by +100
        start_capture();
        fill_ramp(0);
        send_pixels(0, H * W - 1, 0);
        fill_ramp(100);
        send_pixels(0, H * W - 1, 0);
        idle(2);
        check_ramp("b2b", 0, 100, 2);

        // random full-range frames, some gaps
        for (int n = 0; n < 3; n++) begin
            fill_random();
            send_pixels(0, H * W - 1, 30);
        end
        idle(2);

        // reset coinciding with a window's last pixel cancels its pulse
        fill_ramp(0);
        send_pixels(0, 14, 0);
        step(1'b1, 1'b1, frame[0][15], frame[1][15], frame[2][15]);
        idle(2);

        // mid-frame reset after 20 pixels, then a clean ramp frame
        send_pixels(0, 19, 0);
        step(1'b1, 1'b0, 0, 0, 0);
        idle(1);
        check("rst_data_out_1", int'(data_out_1), 0);
        check("rst_valid_out", int'(valid_out), 0);
        fill_ramp(0);
        start_capture();
        send_pixels(0, H * W - 1, 0);
        idle(2);
        check_ramp("after_reset", 0, 0, 1);

        idle(1);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/maxpool_relu.md
# maxpool_relu

Streaming 2×2/stride-2 max-pool and ReLU stage for the three convolution channels. It sits between the second convolution layer and `fully_connected`. It consumes three 8×8 feature maps in raster order, one pixel per channel per accepted cycle. It emits three 4×4 pooled maps in raster order: 16 valid pulses per frame, carrying 48 values in total, which is exactly the buffer fill the fully-connected stage expects.

## Interface
Parameters:
- `IN_WIDTH`, default 8: feature-map columns; must be even.
- `IN_HEIGHT`, default 8: feature-map rows; must be even.
- `DATA_BITS`, default 12: signed sample width, in and out.

Ports:
- `clk`, input, 1: clock.
- `rst_n`, input, 1: reset; synchronous, active-low.
- `valid_in`, input, 1: the three `data_in_*` carry one pixel each this cycle.
- `data_in_1`, `data_in_2`, `data_in_3`, input, `DATA_BITS` signed: channel 1/2/3 pixel.
- `valid_out`, output, 1: one-cycle pulse; the three `data_out_*` hold a pooled result.
- `data_out_1`, `data_out_2`, `data_out_3`, output, `DATA_BITS` signed: pooled channel outputs.
- `frame_done`, output, 1: pulses together with the last `valid_out` of a frame.

## Operation
- Counters:
  - `col` runs 0..`IN_WIDTH`-1 and `row` runs 0..`IN_HEIGHT`-1.
  - Both advance only on `valid_in`; idle cycles between pixels are allowed and freeze all state.
  - `col` wraps to 0 after `IN_WIDTH`-1 and increments `row`.
  - `row` wraps to 0 after `IN_HEIGHT`-1. There is no inter-frame gap requirement.
- Per channel (identical for all three):
  - Even `col`: capture the pixel into `hold`.
  - Even `row`, odd `col`: `linebuf[col/2]` ← max(`hold`, pixel). `linebuf` has `IN_WIDTH`/2 entries.
  - Odd `row`, odd `col`: result ← max(`linebuf[col/2]`, `hold`, pixel), then ReLU (see Configuration), registered to `data_out_n`.
- All comparisons are signed two's-complement on `DATA_BITS`. No widening, no saturation; the output is always one of the inputs, or 0.
- Ties: any equal value may be chosen, since the result is identical.
- Output order: pooled (r,c) for r=0..`IN_HEIGHT`/2-1, c=0..`IN_WIDTH`/2-1, matching fc buffer index order per channel.

## Timing
- Reset values: `valid_out`=0, `frame_done`=0, all `data_out_*`=0, `col`=`row`=0. `hold` and `linebuf` contents are don't-care.
- Latency: `valid_out` rises exactly 1 cycle after the `valid_in` cycle carrying the bottom-right pixel of a window (odd `row`, odd `col`).
- `valid_out` is high for exactly 1 cycle. `data_out_*` hold their value until the next result.
- `frame_done` is high in the same cycle as `valid_out` for window (`IN_HEIGHT`/2-1, `IN_WIDTH`/2-1).
- Back-to-back frames with continuous `valid_in`:
  - Consecutive outputs within a pooled row are 2 cycles apart.
  - There are no outputs during even rows.
  - Row 0 of frame N+1 may overwrite `linebuf` immediately, because frame N's last read happens in the same cycle as its last write opportunity.
- Reset mid-frame:
  - Counters return to 0 and any pending `valid_out` is cancelled.
  - The first pixel after reset is treated as (0,0).
- No backpressure: downstream must accept every `valid_out` pulse.

## Configuration
- `MAXPOOL_RELU_EN` defined: result = (max < 0) ? 0 : max, applied per channel.
- `MAXPOOL_RELU_EN` undefined: pure max-pool; negative maxima pass through unchanged.
- Timing and latency are identical in both builds.

## Structure
- The shared package `cnn_pkg` holds:
  - the `DATA_BITS` default;
  - the signed sample typedef;
  - the feature-map geometry constants (8×8 in, 4×4 out, 3 channels).
- The top level `maxpool_relu` owns the counters, the window-position decode, and `valid_out`/`frame_done`.
- Sub-module `pool_channel` holds `hold`, `linebuf`, the compare tree and ReLU. It is instantiated three times, driven by the shared decode strobes.

## Test plan
- **Ramp frame:** channel 1 pixel = row×8+col (0..63), continuous `valid_in` → 16 pulses with outputs 9, 11, 13, 15, 25, …, 63; `frame_done` on the 16th pulse only.
- **ReLU:** all pixels of channel 2 = -5 (0xFFB) →
  - with `MAXPOOL_RELU_EN`: 16 outputs of 0;
  - without it: 16 outputs of 0xFFB.
- **Signed compare:** one window {-2048, 2047, -1, 0} → 2047; another window {-7, -3, -9, -4} → 0 with ReLU, -3 without.
- **Gapped input:** frame from the ramp case with `valid_in` low on random cycles (≈50%) → same 16 values in the same order, each pulse 1 cycle after the odd/odd pixel.
- **Back-to-back frames:** two ramp frames, the second offset by +100, with no gap → 32 pulses; the second set is 109, 111, …, 163; two `frame_done` pulses.
- **Mid-frame reset:** `rst_n` low for 1 cycle after 20 pixels, then a full ramp frame →
  - the reset cycle cancels any pending `valid_out`, and all outputs read 0 after reset;
  - the next 16 pulses carry exactly the ramp-frame results.
